// File: rtl/hpdcache_core_req_arbiter_if.sv
// Bundle of request/response handshake signals between NREQ requesters,
// the request arbiter and HPDcache core port 0.
//   req_valid/req_ready/req_data : requester-side request channels (flat payload)
//   arb_valid/arb_ready/arb_data/arb_sid : granted request towards the cache
//   cache_rsp_valid/cache_rsp_sid : response beat coming back from the cache
//   rsp_valid : one-hot routed response valid, one bit per requester
// Modport slave is taken by the arbiter, master by its environment.
interface hpdcache_core_req_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned REQ_W = 128,
    parameter int unsigned SID_W = 3
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*REQ_W-1:0] req_data;

    logic                  arb_valid;
    logic                  arb_ready;
    logic [REQ_W-1:0]      arb_data;
    logic [SID_W-1:0]      arb_sid;

    logic                  cache_rsp_valid;
    logic [SID_W-1:0]      cache_rsp_sid;
    logic [NREQ-1:0]       rsp_valid;

    modport slave (
        input  req_valid, req_data, arb_ready, cache_rsp_valid, cache_rsp_sid,
        output req_ready, arb_valid, arb_data, arb_sid, rsp_valid
    );

    modport master (
        output req_valid, req_data, arb_ready, cache_rsp_valid, cache_rsp_sid,
        input  req_ready, arb_valid, arb_data, arb_sid, rsp_valid
    );
endinterface

// File: rtl/hpdcache_core_req_arbiter.sv
// Shares one HPDcache core request port among NREQ requesters.
// Round-robin grant with a hold lock while the cache back-pressures, a
// per-requester in-flight limit, and routing of response beats by source id.
// Ports:
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   bus (slave)    : request channels, cache request/response, routed rsp valid
//   idle_o         : nothing in flight and no lock held
//   err_o          : sticky, response for an sid with nothing outstanding or sid >= NREQ
//   stall_cnt_o    : per-requester stall cycle counters (NREQ*CNT_W)
// Optional feature macro: HPDCACHE_REQ_ARB_PERF_EN enables the saturating
// stall counters; without it stall_cnt_o is tied to zero.
module hpdcache_core_req_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned REQ_W   = 128,
    parameter int unsigned SID_W   = 3,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    hpdcache_core_req_arbiter_if.slave bus,
    output logic                      idle_o,
    output logic                      err_o,
    output logic [NREQ*CNT_W-1:0]     stall_cnt_o
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned OC_W  = $clog2(MAX_OUT + 1);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_e;

    lock_state_e      lock_q;
    logic [PTR_W-1:0] lock_idx_q;
    logic [PTR_W-1:0] ptr_q;
    logic [OC_W-1:0]  out_cnt_q [NREQ];
    logic             err_q;

    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  cnt_zero;
    logic [NREQ-1:0]  rsp_hit;
    logic [NREQ-1:0]  ready_vec;
    logic [PTR_W-1:0] grant;
    logic             found;
    int unsigned      scan_idx;
    logic             arb_valid;
    logic             accept;
    logic             sid_oob;
    logic             err_set;
    logic             all_zero;

    // Requester may compete only while under its in-flight limit
    always_comb begin
        eligible = '0;
        cnt_zero = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = bus.req_valid[i] && (out_cnt_q[i] < OC_W'(MAX_OUT));
            cnt_zero[i] = (out_cnt_q[i] == '0);
        end
    end

    // Round-robin scan from ptr; a held lock overrides the scan
    always_comb begin
        grant    = lock_idx_q;
        found    = 1'b0;
        scan_idx = 0;
        if (lock_q == ST_UNLOCKED) begin
            grant = ptr_q;
            for (int unsigned k = 0; k < NREQ; k++) begin
                scan_idx = (32'(ptr_q) + k) % NREQ;
                if (!found && eligible[PTR_W'(scan_idx)]) begin
                    grant = PTR_W'(scan_idx);
                    found = 1'b1;
                end
            end
        end
    end

    // Outputs are forced quiet while reset is asserted
    assign arb_valid = rst_ni && ((lock_q == ST_LOCKED) || (|eligible));
    assign accept    = arb_valid && bus.arb_ready;
    assign ready_vec = accept ? (NREQ'(1) << grant) : '0;

    assign bus.arb_valid = arb_valid;
    assign bus.arb_sid   = SID_W'(grant);
    assign bus.req_ready = ready_vec;

    // Payload mux on the granted index
    always_comb begin
        bus.arb_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == PTR_W'(i)) begin
                bus.arb_data = bus.req_data[i*REQ_W +: REQ_W];
            end
        end
    end

    // Response routing by source id
    always_comb begin
        rsp_hit = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_hit[i] = bus.cache_rsp_valid && (bus.cache_rsp_sid == SID_W'(i));
        end
    end

    assign bus.rsp_valid = rst_ni ? rsp_hit : '0;
    assign sid_oob       = (32'(bus.cache_rsp_sid) >= NREQ);
    assign err_set       = bus.cache_rsp_valid && (sid_oob || (|(rsp_hit & cnt_zero)));

    // Lock FSM: hold the grant while the cache stalls a presented request
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lock_q     <= ST_UNLOCKED;
            lock_idx_q <= '0;
        end else begin
            if (lock_q == ST_UNLOCKED) begin
                if (arb_valid && !bus.arb_ready) begin
                    lock_q     <= ST_LOCKED;
                    lock_idx_q <= grant;
                end
            end else begin
                if (bus.arb_ready) begin
                    lock_q <= ST_UNLOCKED;
                end
            end
        end
    end

    // Round-robin pointer moves past the requester just accepted
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= PTR_W'((32'(grant) + 1) % NREQ);
        end
    end

    // In-flight counters; a response to an empty counter only flags an error
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREQ; i++) begin
                out_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (ready_vec[i] && !(rsp_hit[i] && !cnt_zero[i])) begin
                    out_cnt_q[i] <= out_cnt_q[i] + OC_W'(1);
                end else if (!ready_vec[i] && rsp_hit[i] && !cnt_zero[i]) begin
                    out_cnt_q[i] <= out_cnt_q[i] - OC_W'(1);
                end
            end
        end
    end

    // Sticky protocol error
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = rst_ni && err_q;

    always_comb begin
        all_zero = &cnt_zero;
    end

    assign idle_o = !rst_ni || (all_zero && (lock_q == ST_UNLOCKED));

`ifdef HPDCACHE_REQ_ARB_PERF_EN
    logic [CNT_W-1:0] stall_q [NREQ];

    // Saturating count of cycles a requester waits with valid high
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREQ; i++) begin
                stall_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && !ready_vec[i] && (stall_q[i] != '1)) begin
                    stall_q[i] <= stall_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        stall_cnt_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            stall_cnt_o[i*CNT_W +: CNT_W] = stall_q[i];
        end
    end
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hpdcache_core_req_arbiter.sv
// Scoreboard bench for hpdcache_core_req_arbiter: stimulus pushes expected
// grants/responses, a negedge monitor pops and compares them.
module tb_hpdcache_core_req_arbiter;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned REQ_W   = 32;
    localparam int unsigned SID_W   = 3;
    localparam int unsigned MAX_OUT = 4;
    localparam int unsigned CNT_W   = 4;
`ifdef HPDCACHE_REQ_ARB_PERF_EN
    localparam logic [15:0] EXP_STALL = 16'h000F;
`else
    localparam logic [15:0] EXP_STALL = 16'h0000;
`endif

    typedef struct packed {
        logic [SID_W-1:0] sid;
        logic [REQ_W-1:0] data;
    } grant_t;

    logic clk;
    logic rst_n;
    logic idle;
    logic err;
    logic [NREQ*CNT_W-1:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    grant_t     exp_grant[$];
    logic [3:0] exp_rsp[$];
    grant_t     g_e;
    logic [3:0] r_e;
    logic [3:0] oh;

    hpdcache_core_req_arbiter_if #(.NREQ(NREQ), .REQ_W(REQ_W), .SID_W(SID_W)) bus ();

    hpdcache_core_req_arbiter #(
        .NREQ(NREQ), .REQ_W(REQ_W), .SID_W(SID_W), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .bus        (bus.slave),
        .idle_o     (idle),
        .err_o      (err),
        .stall_cnt_o(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [REQ_W-1:0] data_of(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0000_0111;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_grant(input int sid);
        grant_t g;
        g.sid  = SID_W'(sid);
        g.data = data_of(sid);
        exp_grant.push_back(g);
    endtask

    task automatic send_rsp(input int sid);
        bus.cache_rsp_valid = 1'b1;
        bus.cache_rsp_sid   = SID_W'(sid);
        if (sid < NREQ) exp_rsp.push_back(4'b0001 << sid);
        tick();
        bus.cache_rsp_valid = 1'b0;
    endtask

    // Monitor: every accepted request and every routed response is matched
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.arb_valid && bus.arb_ready) begin
                if (exp_grant.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL grant_unexpected: got sid %0d expected none", bus.arb_sid);
                end else begin
                    g_e = exp_grant.pop_front();
                    oh  = 4'b0001 << g_e.sid;
                    chk("grant_sid", 64'(bus.arb_sid), 64'(g_e.sid));
                    chk("grant_data", 64'(bus.arb_data), 64'(g_e.data));
                    chk("grant_ready", 64'(bus.req_ready), 64'(oh));
                end
            end
            if (bus.rsp_valid != '0) begin
                if (exp_rsp.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rsp_unexpected: got %0h expected none", bus.rsp_valid);
                end else begin
                    r_e = exp_rsp.pop_front();
                    chk("rsp_route", 64'(bus.rsp_valid), 64'(r_e));
                end
            end
        end
    end

    initial begin
        rst_n               = 1'b0;
        bus.req_valid       = 4'b1111;
        bus.arb_ready       = 1'b1;
        bus.cache_rsp_valid = 1'b1;
        bus.cache_rsp_sid   = 3'd1;
        for (int i = 0; i < NREQ; i++) bus.req_data[i*REQ_W +: REQ_W] = data_of(i);

        // Reset state with inputs active
        tick();
        @(negedge clk);
        chk("rst_arb_valid", 64'(bus.arb_valid), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_err", 64'(err), 64'd0);
        tick();
        rst_n               = 1'b1;
        bus.req_valid       = 4'b0000;
        bus.cache_rsp_valid = 1'b0;

        // Round-robin with all requesters valid
        for (int k = 0; k < 8; k++) push_grant(k % 4);
        bus.req_valid = 4'b1111;
        repeat (8) tick();
        bus.req_valid = 4'b0000;
        @(negedge clk);
        chk("rr_idle_busy", 64'(idle), 64'd0);
        for (int k = 0; k < 8; k++) send_rsp(k % 4);
        @(negedge clk);
        chk("rr_idle_drained", 64'(idle), 64'd1);

        // Lock on requester 2 while the cache stalls
        bus.arb_ready = 1'b0;
        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("lock_sid_c0", 64'(bus.arb_sid), 64'd2);
        chk("lock_ready_c0", 64'(bus.req_ready), 64'd0);
        tick();
        @(negedge clk);
        chk("lock_sid_c1", 64'(bus.arb_sid), 64'd2);
        tick();
        bus.req_valid = 4'b0101;
        @(negedge clk);
        chk("lock_sid_c2", 64'(bus.arb_sid), 64'd2);
        chk("lock_valid_c2", 64'(bus.arb_valid), 64'd1);
        tick();
        bus.arb_ready = 1'b1;
        push_grant(2);
        tick();
        bus.req_valid = 4'b0001;
        push_grant(0);
        tick();
        bus.req_valid = 4'b0000;
        send_rsp(2);
        send_rsp(0);

        // In-flight limit on requester 1
        bus.req_valid = 4'b0010;
        for (int k = 0; k < 4; k++) push_grant(1);
        repeat (4) tick();
        bus.req_valid = 4'b1010;
        push_grant(3);
        @(negedge clk);
        chk("limit_ready1_blocked", 64'(bus.req_ready[1]), 64'd0);
        tick();
        bus.req_valid = 4'b0010;
        bus.cache_rsp_valid = 1'b1;
        bus.cache_rsp_sid   = 3'd1;
        exp_rsp.push_back(4'b0010);
        @(negedge clk);
        chk("limit_no_grant", 64'(bus.arb_valid), 64'd0);
        tick();
        bus.cache_rsp_valid = 1'b0;
        push_grant(1);
        @(negedge clk);
        chk("limit_ready1_again", 64'(bus.req_ready[1]), 64'd1);
        tick();
        bus.req_valid = 4'b0000;
        for (int k = 0; k < 4; k++) send_rsp(1);
        send_rsp(3);
        @(negedge clk);
        chk("limit_idle", 64'(idle), 64'd1);

        // Accept and response for requester 0 in the same cycle
        bus.req_valid = 4'b0001;
        push_grant(0);
        push_grant(0);
        repeat (2) tick();
        bus.cache_rsp_valid = 1'b1;
        bus.cache_rsp_sid   = 3'd0;
        exp_rsp.push_back(4'b0001);
        push_grant(0);
        tick();
        bus.req_valid       = 4'b0000;
        bus.cache_rsp_valid = 1'b0;
        send_rsp(0);
        @(negedge clk);
        chk("same_cycle_busy", 64'(idle), 64'd0);
        send_rsp(0);
        @(negedge clk);
        chk("same_cycle_idle", 64'(idle), 64'd1);
        chk("same_cycle_no_err", 64'(err), 64'd0);

        // Sticky error on response with nothing outstanding
        send_rsp(3);
        @(negedge clk);
        chk("err_set", 64'(err), 64'd1);
        tick();
        tick();
        @(negedge clk);
        chk("err_sticky", 64'(err), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("err_cleared", 64'(err), 64'd0);
        bus.cache_rsp_valid = 1'b1;
        bus.cache_rsp_sid   = 3'd5;
        @(negedge clk);
        chk("oob_no_route", 64'(bus.rsp_valid), 64'd0);
        tick();
        bus.cache_rsp_valid = 1'b0;
        @(negedge clk);
        chk("oob_err", 64'(err), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Stall counting while requester 0 is held off
        bus.arb_ready = 1'b0;
        bus.req_valid = 4'b0001;
        repeat (20) tick();
        @(negedge clk);
        chk("stall_cnt", 64'(stall_cnt), 64'(EXP_STALL));
        bus.arb_ready = 1'b1;
        push_grant(0);
        tick();
        bus.arb_ready = 1'b0;
        bus.req_valid = 4'b0100;
        tick();
        @(negedge clk);
        chk("midlock_sid", 64'(bus.arb_sid), 64'd2);
        chk("midlock_busy", 64'(idle), 64'd0);

        // Reset while locked
        rst_n = 1'b0;
        @(negedge clk);
        chk("midlock_rst_valid", 64'(bus.arb_valid), 64'd0);
        tick();
        rst_n         = 1'b1;
        bus.req_valid = 4'b0000;
        @(negedge clk);
        chk("post_rst_valid", 64'(bus.arb_valid), 64'd0);
        chk("post_rst_idle", 64'(idle), 64'd1);
        chk("post_rst_stall", 64'(stall_cnt), 64'd0);
        bus.arb_ready = 1'b1;
        bus.req_valid = 4'b1111;
        push_grant(0);
        tick();
        bus.req_valid = 4'b0000;

        // Bounded drain of outstanding expectations
        for (int k = 0; k < 10 && (exp_grant.size() != 0 || exp_rsp.size() != 0); k++) tick();
        chk("sb_grant_left", 64'(exp_grant.size()), 64'd0);
        chk("sb_rsp_left", 64'(exp_rsp.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
